// File: rtl/voice_alloc.sv
// voice_alloc: maps MIDI note on/off events onto NVOICE synth slots, stealing the least-recently-allocated slot.
// Fixed 2-cycle strobe-to-command latency; no backpressure, strobes seen while busy are dropped.
module voice_alloc #(
  parameter int NVOICE = 4,
  parameter int VW     = $clog2(NVOICE)
) (
  input  logic              clk32,
  input  logic              rst,
  input  logic              note_pressed,
  input  logic              note_released,
  input  logic [6:0]        note,
  input  logic [6:0]        velocity,
  input  logic [3:0]        channel,
  output logic              busy,
  output logic              voice_valid,
  output logic [VW-1:0]     voice_idx,
  output logic              voice_gate,
  output logic [6:0]        voice_note,
  output logic [6:0]        voice_vel,
  output logic              voice_steal,
  output logic [NVOICE-1:0] active
);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_EMIT} state_t;

  state_t              state_q;
  logic                busy_q;
  logic                ev_press_q;
  logic [6:0]          ev_note_q;
  logic [6:0]          ev_vel_q;
  logic [3:0]          ev_ch_q;
  logic [NVOICE-1:0]   act_q;
  logic [6:0]          slot_note_q [NVOICE];
  logic [3:0]          slot_ch_q   [NVOICE];
  logic [VW-1:0]       rank_q      [NVOICE];
  logic [VW-1:0]       sel_q;
  logic                sel_steal_q;
  logic                voice_valid_q;
  logic [VW-1:0]       voice_idx_q;
  logic                voice_gate_q;
  logic [6:0]          voice_note_q;
  logic [6:0]          voice_vel_q;
  logic                voice_steal_q;
  logic [NVOICE-1:0]   active_q;

  logic                hit_d;
  logic [VW-1:0]       hit_idx_d;
  logic                free_d;
  logic [VW-1:0]       free_idx_d;
  logic [VW-1:0]       oldest_idx_d;
  logic [VW-1:0]       pick_idx_d;
  logic                pick_steal_d;
  logic [VW-1:0]       pick_rank_d;

  // Descending scan so the lowest matching index is the one that sticks.
  always_comb begin
    hit_d        = 1'b0;
    hit_idx_d    = '0;
    free_d       = 1'b0;
    free_idx_d   = '0;
    oldest_idx_d = '0;
    for (int i = NVOICE - 1; i >= 0; i--) begin
      if (act_q[i] && slot_note_q[i] == ev_note_q && slot_ch_q[i] == ev_ch_q) begin
        hit_d     = 1'b1;
        hit_idx_d = VW'(i);
      end
      if (!act_q[i]) begin
        free_d     = 1'b1;
        free_idx_d = VW'(i);
      end
      if (rank_q[i] == VW'(NVOICE - 1)) begin
        oldest_idx_d = VW'(i);
      end
    end
    pick_idx_d   = hit_d ? hit_idx_d : (free_d ? free_idx_d : oldest_idx_d);
    pick_steal_d = !hit_d && !free_d;
    pick_rank_d  = rank_q[pick_idx_d];
  end

  always_ff @(posedge clk32) begin
    if (rst) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      ev_press_q    <= 1'b0;
      ev_note_q     <= '0;
      ev_vel_q      <= '0;
      ev_ch_q       <= '0;
      act_q         <= '0;
      sel_q         <= '0;
      sel_steal_q   <= 1'b0;
      voice_valid_q <= 1'b0;
      voice_idx_q   <= '0;
      voice_gate_q  <= 1'b0;
      voice_note_q  <= '0;
      voice_vel_q   <= '0;
      voice_steal_q <= 1'b0;
      active_q      <= '0;
      for (int i = 0; i < NVOICE; i++) begin
        slot_note_q[i] <= '0;
        slot_ch_q[i]   <= '0;
        rank_q[i]      <= VW'(i);
      end
    end else begin
      voice_valid_q <= 1'b0;
      voice_steal_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (note_pressed || note_released) begin
            // A press with zero velocity is a note-off; a press beats a simultaneous release.
            ev_press_q <= note_pressed && (velocity != 7'd0);
            ev_note_q  <= note;
            ev_vel_q   <= velocity;
            ev_ch_q    <= channel;
            busy_q     <= 1'b1;
            state_q    <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (ev_press_q) begin
            for (int i = 0; i < NVOICE; i++) begin
              if (VW'(i) == pick_idx_d) begin
                act_q[i]       <= 1'b1;
                slot_note_q[i] <= ev_note_q;
                slot_ch_q[i]   <= ev_ch_q;
                rank_q[i]      <= '0;
              end else if (rank_q[i] < pick_rank_d) begin
                rank_q[i] <= rank_q[i] + VW'(1);
              end
            end
            sel_q       <= pick_idx_d;
            sel_steal_q <= pick_steal_d;
            state_q     <= S_EMIT;
          end else if (hit_d) begin
            act_q[hit_idx_d] <= 1'b0;
            sel_q            <= hit_idx_d;
            sel_steal_q      <= 1'b0;
            state_q          <= S_EMIT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_EMIT: begin
          voice_valid_q <= 1'b1;
          voice_idx_q   <= sel_q;
          voice_gate_q  <= ev_press_q;
          voice_note_q  <= ev_note_q;
          voice_vel_q   <= ev_vel_q;
          voice_steal_q <= sel_steal_q;
          active_q      <= act_q;
          busy_q        <= 1'b0;
          state_q       <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign voice_valid = voice_valid_q;
  assign voice_idx   = voice_idx_q;
  assign voice_gate  = voice_gate_q;
  assign voice_note  = voice_note_q;
  assign voice_vel   = voice_vel_q;
  assign voice_steal = voice_steal_q;
  assign active      = active_q;

endmodule

// File: tb/tb_voice_alloc.sv
// Bench for voice_alloc: fixed vector table, hand-written corner sequences, and random events against an LRU-queue model.
module tb_voice_alloc;
  localparam int NV = 4;

  logic       clk32 = 1'b0;
  logic       rst;
  logic       note_pressed;
  logic       note_released;
  logic [6:0] note;
  logic [6:0] velocity;
  logic [3:0] channel;
  logic       busy;
  logic       voice_valid;
  logic [1:0] voice_idx;
  logic       voice_gate;
  logic [6:0] voice_note;
  logic [6:0] voice_vel;
  logic       voice_steal;
  logic [3:0] active;

  always #5 clk32 = ~clk32;

  voice_alloc #(.NVOICE(NV)) dut (
    .clk32(clk32), .rst(rst),
    .note_pressed(note_pressed), .note_released(note_released),
    .note(note), .velocity(velocity), .channel(channel),
    .busy(busy), .voice_valid(voice_valid), .voice_idx(voice_idx),
    .voice_gate(voice_gate), .voice_note(voice_note), .voice_vel(voice_vel),
    .voice_steal(voice_steal), .active(active)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  typedef struct {
    int vcnt; int vpos; int bcnt;
    int idx; int gate; int nt; int vel; int steal; int act;
  } obs_t;

  typedef struct {
    bit p; bit r; int n; int v; int c;
    bit ev; int idx; bit g; bit st; int act;
  } vec_t;

  task automatic do_reset();
    @(negedge clk32);
    rst = 1'b1; note_pressed = 1'b0; note_released = 1'b0;
    note = '0; velocity = '0; channel = '0;
    repeat (2) @(posedge clk32);
    @(negedge clk32);
    rst = 1'b0;
  endtask

  // Sample j is taken 1 time unit after the j-th edge following the accepting edge.
  task automatic run_ev(input bit p, input bit r, input int n, input int v, input int c, output obs_t o);
    @(negedge clk32);
    note_pressed = p; note_released = r;
    note = 7'(n); velocity = 7'(v); channel = 4'(c);
    @(posedge clk32); #1;
    note_pressed = 1'b0; note_released = 1'b0;
    o.vcnt = 0; o.vpos = -1; o.bcnt = 0;
    o.idx = 0; o.gate = 0; o.nt = 0; o.vel = 0; o.steal = 0; o.act = 0;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) begin @(posedge clk32); #1; end
      if (busy) o.bcnt++;
      if (voice_valid) begin
        o.vcnt++;
        if (o.vpos < 0) begin
          o.vpos = j; o.idx = int'(voice_idx); o.gate = int'(voice_gate);
          o.nt = int'(voice_note); o.vel = int'(voice_vel); o.steal = int'(voice_steal);
        end
      end
    end
    o.act = int'(active);
  endtask

  task automatic check_obs(input string tag, input obs_t o, input bit ev, input int idx, input bit g,
                           input int n, input int v, input bit st, input int act);
    chk({tag, ".valid_cnt"}, o.vcnt, ev ? 1 : 0);
    if (ev) begin
      chk({tag, ".valid_cycle"}, o.vpos, 2);
      chk({tag, ".busy_cycles"}, o.bcnt, 2);
      chk({tag, ".idx"}, o.idx, idx);
      chk({tag, ".gate"}, o.gate, int'(g));
      chk({tag, ".note"}, o.nt, n);
      chk({tag, ".vel"}, o.vel, v);
      chk({tag, ".steal"}, o.steal, int'(st));
    end else begin
      chk({tag, ".busy_cycles"}, o.bcnt, 1);
    end
    chk({tag, ".active"}, o.act, act);
  endtask

  // Reference model: slot contents plus an allocation-order queue, newest at the front.
  bit m_act [NV];
  int m_note[NV];
  int m_ch  [NV];
  int order [$];

  task automatic model_reset();
    order = {};
    for (int i = 0; i < NV; i++) begin
      order.push_back(i);
      m_act[i] = 1'b0; m_note[i] = 0; m_ch[i] = 0;
    end
  endtask

  task automatic model_ev(input bit p, input bit r, input int n, input int v, input int c,
                          output bit ev, output int idx, output bit g, output bit st);
    bit press;
    int hit;
    int fr;
    press = p && (v != 0);
    hit = -1; fr = -1;
    ev = 1'b0; idx = 0; g = 1'b0; st = 1'b0;
    for (int i = 0; i < NV; i++) begin
      if (hit < 0 && m_act[i] && m_note[i] == n && m_ch[i] == c) hit = i;
      if (fr < 0 && !m_act[i]) fr = i;
    end
    if (press) begin
      if (hit >= 0) idx = hit;
      else if (fr >= 0) idx = fr;
      else begin idx = order[order.size() - 1]; st = 1'b1; end
      for (int k = 0; k < order.size(); k++) begin
        if (order[k] == idx) begin order.delete(k); break; end
      end
      order.push_front(idx);
      m_act[idx] = 1'b1; m_note[idx] = n; m_ch[idx] = c;
      ev = 1'b1; g = 1'b1;
    end else if ((p || r) && hit >= 0) begin
      idx = hit; m_act[hit] = 1'b0; ev = 1'b1;
    end
  endtask

  function automatic int model_active();
    int a;
    a = 0;
    for (int i = 0; i < NV; i++) if (m_act[i]) a |= (1 << i);
    return a;
  endfunction

  vec_t vt[15];

  initial begin
    obs_t o;
    int   vc;
    bit   e_ev; int e_idx; bit e_g; bit e_st;
    bit   rp; bit rr; int rn; int rv; int rc; int kind;

    vt[0]  = '{1'b1, 1'b0, 60, 100, 0, 1'b1, 0, 1'b1, 1'b0, 4'b0001};
    vt[1]  = '{1'b1, 1'b0, 62,  90, 0, 1'b1, 1, 1'b1, 1'b0, 4'b0011};
    vt[2]  = '{1'b1, 1'b0, 64,  80, 0, 1'b1, 2, 1'b1, 1'b0, 4'b0111};
    vt[3]  = '{1'b1, 1'b0, 65,  70, 0, 1'b1, 3, 1'b1, 1'b0, 4'b1111};
    vt[4]  = '{1'b0, 1'b1, 62,  40, 0, 1'b1, 1, 1'b0, 1'b0, 4'b1101};
    vt[5]  = '{1'b1, 1'b0, 62,  55, 0, 1'b1, 1, 1'b1, 1'b0, 4'b1111};
    vt[6]  = '{1'b1, 1'b0, 67, 101, 0, 1'b1, 0, 1'b1, 1'b1, 4'b1111};
    vt[7]  = '{1'b1, 1'b0, 69, 102, 0, 1'b1, 2, 1'b1, 1'b1, 4'b1111};
    vt[8]  = '{1'b1, 1'b0, 69,  20, 0, 1'b1, 2, 1'b1, 1'b0, 4'b1111};
    vt[9]  = '{1'b1, 1'b0, 69,  50, 1, 1'b1, 3, 1'b1, 1'b1, 4'b1111};
    vt[10] = '{1'b1, 1'b0, 67,   0, 0, 1'b1, 0, 1'b0, 1'b0, 4'b1110};
    vt[11] = '{1'b0, 1'b1, 99,  10, 0, 1'b0, 0, 1'b0, 1'b0, 4'b1110};
    vt[12] = '{1'b1, 1'b0, 71,   0, 0, 1'b0, 0, 1'b0, 1'b0, 4'b1110};
    vt[13] = '{1'b1, 1'b1, 72,  30, 0, 1'b1, 0, 1'b1, 1'b0, 4'b1111};
    vt[14] = '{1'b0, 1'b1, 72,  10, 0, 1'b1, 0, 1'b0, 1'b0, 4'b1110};

    rst = 1'b1; note_pressed = 1'b0; note_released = 1'b0;
    note = '0; velocity = '0; channel = '0;
    do_reset();
    #1;
    chk("reset.busy",   int'(busy), 0);
    chk("reset.valid",  int'(voice_valid), 0);
    chk("reset.steal",  int'(voice_steal), 0);
    chk("reset.gate",   int'(voice_gate), 0);
    chk("reset.idx",    int'(voice_idx), 0);
    chk("reset.note",   int'(voice_note), 0);
    chk("reset.vel",    int'(voice_vel), 0);
    chk("reset.active", int'(active), 0);

    for (int k = 0; k < 15; k++) begin
      run_ev(vt[k].p, vt[k].r, vt[k].n, vt[k].v, vt[k].c, o);
      check_obs($sformatf("vec%0d", k), o, vt[k].ev, vt[k].idx, vt[k].g, vt[k].n, vt[k].v, vt[k].st, vt[k].act);
    end

    // Strobes during SEARCH and EMIT must be dropped.
    do_reset();
    @(negedge clk32);
    note_pressed = 1'b1; note = 7'd80; velocity = 7'd60; channel = 4'd0;
    @(posedge clk32); #1;
    note = 7'd81;
    @(posedge clk32);
    @(posedge clk32); #1;
    note_pressed = 1'b0;
    chk("busy_drop.valid", int'(voice_valid), 1);
    chk("busy_drop.note",  int'(voice_note), 80);
    vc = 0;
    for (int j = 0; j < 5; j++) begin
      @(posedge clk32); #1;
      if (voice_valid) vc++;
    end
    chk("busy_drop.extra_valid", vc, 0);
    chk("busy_drop.active", int'(active), 4'b0001);
    chk("busy_drop.hold_note", int'(voice_note), 80);

    // Reset asserted while in SEARCH aborts the event.
    do_reset();
    @(negedge clk32);
    note_pressed = 1'b1; note = 7'd60; velocity = 7'd100; channel = 4'd0;
    @(posedge clk32); #1;
    note_pressed = 1'b0; rst = 1'b1;
    @(posedge clk32); #1;
    rst = 1'b0;
    chk("rst_search.busy",   int'(busy), 0);
    chk("rst_search.active", int'(active), 0);
    vc = 0;
    for (int j = 0; j < 4; j++) begin
      if (voice_valid) vc++;
      @(posedge clk32); #1;
    end
    chk("rst_search.valid_cnt", vc, 0);
    chk("rst_search.active_after", int'(active), 0);

    // Random events against the model.
    do_reset();
    model_reset();
    for (int k = 0; k < 250; k++) begin
      kind = $urandom_range(0, 3);
      rp = (kind == 0 || kind == 2);
      rr = (kind == 1 || kind == 2);
      if (kind == 3) begin rp = 1'b1; rr = 1'b0; end
      rn = 60 + $urandom_range(0, 5);
      rc = $urandom_range(0, 1);
      rv = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 127);
      model_ev(rp, rr, rn, rv, rc, e_ev, e_idx, e_g, e_st);
      run_ev(rp, rr, rn, rv, rc, o);
      check_obs($sformatf("rnd%0d", k), o, e_ev, e_idx, e_g, rn, rv, e_st, model_active());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
